cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter sharing the single common data bus (CDB) among the functional-unit result FIFOs (rs_alu instances plus other units) in the RV32I superscalar core.
- Each cycle it selects at most one requester and pops that requester's FIFO head via a one-cycle grant.
- It then broadcasts the selected ROB tag/value on a registered CDB to the ROB and reservation stations.

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- XLEN, 32, result value width.
- TAG_W, 6, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  pipeline stall; freezes arbiter.
- flush_i  in  1  branch-mispredict flush; kills the current broadcast.
- req_i  in  N_REQ  bit k set: FU k FIFO non-empty (inverse of its fifo_empty).
- tag_i  in  N_REQ*TAG_W  FU k head tag at bits [k*TAG_W +: TAG_W].
- value_i  in  N_REQ*XLEN  FU k head value at bits [k*XLEN +: XLEN].
- grant_o  out  N_REQ  one-hot pop strobe to FU k FIFO (drives its cdb_en).
- cdb_valid_o  out  1  broadcast valid.
- cdb_tag_o  out  TAG_W  broadcast ROB tag.
- cdb_value_o  out  XLEN  broadcast result.
- cdb_src_o  out  clog2(N_REQ)  index of the FU being broadcast.
- bcast_cnt_o  out  32  count of completed broadcasts.

Behaviour:
- Reset (rst=1 at clk edge): ptr=0, cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0, cdb_src_o=0, bcast_cnt_o=0.
  - grant_o is combinational and is forced to 0 while rst=1.
  - Reset mid-operation drops any pending broadcast; no FIFO is popped that cycle.
- Grant is combinational, same cycle:
  - Among set req_i bits, pick the first index at or after ptr, searching upward with wrap modulo N_REQ.
  - grant_o is one-hot for that index, or all-zero if req_i==0, stall_i=1 or flush_i=1.
  - Requesters must not depend on grant_o to form req_i (no combinational loop).
- Broadcast is registered, 1-cycle latency:
  - On an edge where grant_o[k]=1: cdb_valid_o<=1, cdb_tag_o<=tag_i[k], cdb_value_o<=value_i[k], cdb_src_o<=k, ptr<=(k+1) mod N_REQ.
  - On an edge with no grant, no stall and no flush: cdb_valid_o<=0. Tag, value and src hold their last values (don't-care while invalid).
- Counter: bcast_cnt_o increments by 1 on each edge where a grant is taken. It wraps at 2^32 to 0.
- stall_i=1 (and flush_i=0):
  - No grant.
  - ptr, all cdb_* registers and bcast_cnt_o hold.
  - A valid broadcast stays visible for the entire stall; consumers are stalled by the same signal.
- flush_i=1 (priority over stall_i):
  - No grant.
  - cdb_valid_o<=0 next edge; ptr and bcast_cnt_o hold.
  - An FU's FIFO is not popped on a flush cycle. The FU flushes its own contents.
- Fairness:
  - A continuously requesting FU is granted within N_REQ non-stalled, non-flushed cycles.
  - With all N_REQ requesting, grants rotate 0,1,..,N_REQ-1,0.
- Back-to-back: a FU may be granted in consecutive cycles only if it is the sole requester.
- Single requester: granted every non-stalled cycle, giving one broadcast per cycle.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, then req_i=4'b0001, tag_i[0]=12, value_i[0]=48.
  - Same cycle: grant_o=0001.
  - Next cycle: cdb_valid_o=1, cdb_tag_o=12, cdb_value_o=48, cdb_src_o=0, bcast_cnt_o=1.
- Round robin: req_i=4'b1111 held for 8 cycles.
  - grant_o sequence: 0001,0010,0100,1000,0001,0010,0100,1000.
  - bcast_cnt_o=8.
- Pointer wrap/skip: after granting FU2, req_i=4'b0011.
  - Next grant is FU0 (search 3→0), then FU1.
- Stall: req_i=4'b0110 with a broadcast of tag 5 valid, then stall_i=1 for 3 cycles.
  - grant_o=0 throughout.
  - cdb_valid_o=1 and cdb_tag_o=5 held.
  - After release, the next grant goes to the FU following the previous winner.
- Flush during stall: stall_i=1 and flush_i=1 together with cdb_valid_o=1.
  - Next cycle: cdb_valid_o=0, grant_o=0, bcast_cnt_o unchanged.
- Reset mid-stream: rst=1 while req_i=4'b1111 and cdb_valid_o=1.
  - grant_o=0 during reset.
  - Next cycle: cdb_valid_o=0, bcast_cnt_o=0.
  - After reset, first grant is FU0.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin arbiter for the common data bus (CDB). Each cycle it
//            picks at most one functional-unit result FIFO, pops its head with
//            a one-cycle grant, and broadcasts the head tag/value on a
//            registered CDB to the ROB and reservation stations.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            stall_i          - freezes arbitration and all CDB state
//            flush_i          - kills the broadcast; takes priority over stall
//            req_i[N_REQ]     - FU k FIFO non-empty
//            tag_i, value_i   - FU k head tag/value, packed k-major
//            grant_o[N_REQ]   - one-hot combinational pop strobe
//            cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_src_o - registered bus
//            bcast_cnt_o      - count of broadcasts taken (wraps at 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*TAG_W-1:0]    tag_i,
  input  logic [N_REQ*XLEN-1:0]     value_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [XLEN-1:0]           cdb_value_o,
  output logic [$clog2(N_REQ)-1:0]  cdb_src_o,
  output logic [31:0]               bcast_cnt_o
);

  localparam int SRC_W = $clog2(N_REQ);
  // Candidate index is one bit wider so ptr + offset never overflows
  // before the modulo-N_REQ correction.
  localparam logic [SRC_W:0]   c_N_REQ = (SRC_W+1)'(N_REQ);
  localparam logic [SRC_W-1:0] c_LAST  = SRC_W'(N_REQ - 1);

  logic [SRC_W-1:0] r_ptr;
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_value;
  logic [SRC_W-1:0] r_src;
  logic [31:0]      r_cnt;

  logic [SRC_W:0]   w_cand;
  logic [SRC_W-1:0] w_sel;
  logic             w_found;
  logic             w_take;
  logic [SRC_W-1:0] w_ptr_next;

  // Search upward from r_ptr with wrap; first requester wins.
  always_comb begin
    w_cand  = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, r_ptr} + (SRC_W+1)'(i);
      if (w_cand >= c_N_REQ) begin
        w_cand = w_cand - c_N_REQ;
      end
      if (!w_found && req_i[w_cand[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[SRC_W-1:0];
      end
    end
  end

  // A grant pops a FIFO, so it must be suppressed whenever the broadcast
  // register will not actually capture the head (reset, stall, flush).
  assign w_take = w_found && !stall_i && !flush_i && !rst;

  always_comb begin
    grant_o        = '0;
    grant_o[w_sel] = w_take;
  end

  assign w_ptr_next = (w_sel == c_LAST) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_value <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (stall_i) begin
      // Hold everything: consumers are frozen by the same stall.
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_tag   <= tag_i[w_sel*TAG_W +: TAG_W];
      r_value <= value_i[w_sel*XLEN +: XLEN];
      r_src   <= w_sel;
      r_ptr   <= w_ptr_next;
      r_cnt   <= r_cnt + 32'd1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign cdb_valid_o = r_valid;
  assign cdb_tag_o   = r_tag;
  assign cdb_value_o = r_value;
  assign cdb_src_o   = r_src;
  assign bcast_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Directed vector bench for cdb_arbiter (N_REQ=4). FU k drives
//            tag = base + k and value = 4 * tag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N_REQ = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     stall_i = 1'b0;
  logic                     flush_i = 1'b0;
  logic [N_REQ-1:0]         req_i = '0;
  logic [N_REQ*TAG_W-1:0]   tag_i = '0;
  logic [N_REQ*XLEN-1:0]    value_i = '0;
  logic [N_REQ-1:0]         grant_o;
  logic                     cdb_valid_o;
  logic [TAG_W-1:0]         cdb_tag_o;
  logic [XLEN-1:0]          cdb_value_o;
  logic [1:0]               cdb_src_o;
  logic [31:0]              bcast_cnt_o;

  cdb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .req_i       (req_i),
    .tag_i       (tag_i),
    .value_i     (value_i),
    .grant_o     (grant_o),
    .cdb_valid_o (cdb_valid_o),
    .cdb_tag_o   (cdb_tag_o),
    .cdb_value_o (cdb_value_o),
    .cdb_src_o   (cdb_src_o),
    .bcast_cnt_o (bcast_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       flush;
    logic [3:0] req;
    int         tbase;
    logic [3:0] grant;   // expected same cycle
    logic       valid;   // expected after the edge
    int         tag;
    int         src;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(logic r, logic s, logic f, logic [3:0] rq, int tb,
                              logic [3:0] g, logic v, int tg, int sr, int c);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.req = rq; x.tbase = tb;
    x.grant = g; x.valid = v; x.tag = tg; x.src = sr; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [3:0] rq, input int tb);
    rst = r; stall_i = s; flush_i = f; req_i = rq;
    for (int k = 0; k < N_REQ; k++) begin
      tag_i[k*TAG_W +: TAG_W]  = TAG_W'(tb + k);
      value_i[k*XLEN +: XLEN]  = 32'((tb + k) * 4);
    end
  endtask

  int gcount[N_REQ];

  initial begin
    //            rst st fl req     tb  grant   v  tag src cnt
    vecs.push_back(mk(1,0,0,4'b0000, 0,4'b0000,0, 0,0, 0));  // reset
    vecs.push_back(mk(1,0,0,4'b1111, 0,4'b0000,0, 0,0, 0));  // grant forced 0
    vecs.push_back(mk(0,0,0,4'b0001,12,4'b0001,1,12,0, 1));  // single request
    vecs.push_back(mk(0,0,0,4'b1000, 0,4'b1000,1, 3,3, 2));  // ptr -> 0
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0001,1, 0,0, 3));  // round robin x8
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0010,1, 1,1, 4));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0100,1, 2,2, 5));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b1000,1, 3,3, 6));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0001,1, 0,0, 7));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0010,1, 1,1, 8));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0100,1, 2,2, 9));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b1000,1, 3,3,10));
    vecs.push_back(mk(0,0,0,4'b0000, 0,4'b0000,0, 0,0,10));  // idle
    vecs.push_back(mk(0,0,0,4'b0100, 0,4'b0100,1, 2,2,11));  // grant FU2
    vecs.push_back(mk(0,0,0,4'b0011, 0,4'b0001,1, 0,0,12));  // wrap 3->0
    vecs.push_back(mk(0,0,0,4'b0011, 0,4'b0010,1, 1,1,13));
    vecs.push_back(mk(0,0,0,4'b0110, 3,4'b0100,1, 5,2,14));  // tag 5 on bus
    vecs.push_back(mk(0,1,0,4'b0110, 3,4'b0000,1, 5,2,14));  // stall x3
    vecs.push_back(mk(0,1,0,4'b0110, 3,4'b0000,1, 5,2,14));
    vecs.push_back(mk(0,1,0,4'b0110, 3,4'b0000,1, 5,2,14));
    vecs.push_back(mk(0,0,0,4'b0110, 3,4'b0010,1, 4,1,15));  // after FU2 -> FU1
    vecs.push_back(mk(0,0,0,4'b0010, 0,4'b0010,1, 1,1,16));  // sole requester
    vecs.push_back(mk(0,0,0,4'b0010, 0,4'b0010,1, 1,1,17));  // back-to-back
    vecs.push_back(mk(0,1,1,4'b1111, 0,4'b0000,0, 0,0,17));  // flush + stall
    vecs.push_back(mk(0,0,1,4'b1111, 0,4'b0000,0, 0,0,17));  // flush only
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0100,1, 2,2,18));  // ptr held at 2
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b1000,1, 3,3,19));
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0001,1, 0,0,20));
    vecs.push_back(mk(1,0,0,4'b1111, 0,4'b0000,0, 0,0, 0));  // reset mid-stream
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0001,1, 0,0, 1));  // restarts at FU0
    vecs.push_back(mk(0,0,0,4'b1111, 0,4'b0010,1, 1,1, 2));

    drive(1, 0, 0, 4'b0000, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].req, vecs[i].tbase);
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(vecs[i].grant));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), 32'(cdb_valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d cnt", i), bcast_cnt_o, 32'(vecs[i].cnt));
      if (vecs[i].valid || vecs[i].rst) begin
        chk($sformatf("v%0d tag", i), 32'(cdb_tag_o), 32'(vecs[i].tag));
        chk($sformatf("v%0d value", i), cdb_value_o, 32'(vecs[i].tag * 4));
        chk($sformatf("v%0d src", i), 32'(cdb_src_o), 32'(vecs[i].src));
      end
    end

    // Stall must freeze the bus even while the FIFO heads change.
    // ptr is 2 here, so FU0 as sole requester is still found.
    drive(0, 0, 0, 4'b0001, 20);
    @(posedge clk); #1;
    chk("hold setup tag", 32'(cdb_tag_o), 32'd20);
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, 0, 4'b0001, 30);
      #1;
      chk($sformatf("hold grant c%0d", c), 32'(grant_o), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("hold tag c%0d", c), 32'(cdb_tag_o), 32'd20);
      chk($sformatf("hold value c%0d", c), cdb_value_o, 32'd80);
      chk($sformatf("hold cnt c%0d", c), bcast_cnt_o, 32'd3);
    end

    // Fairness: 2*N_REQ cycles all requesting -> each FU exactly twice,
    // never the same FU twice in a row.
    for (int k = 0; k < N_REQ; k++) gcount[k] = 0;
    begin
      logic [3:0] prev;
      prev = 4'b0000;
      for (int c = 0; c < 2 * N_REQ; c++) begin
        drive(0, 0, 0, 4'b1111, 0);
        #1;
        for (int k = 0; k < N_REQ; k++) if (grant_o[k]) gcount[k]++;
        chk($sformatf("fair onehot c%0d", c), 32'($countones(grant_o)), 32'd1);
        chk($sformatf("fair nonrepeat c%0d", c), 32'(grant_o == prev), 32'd0);
        prev = grant_o;
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < N_REQ; k++)
      chk($sformatf("fair count FU%0d", k), 32'(gcount[k]), 32'd2);
    chk("fair total cnt", bcast_cnt_o, 32'd11);

    drive(0, 0, 0, 4'b0000, 0);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
